// File: rtl/pc_seq_ctrl_if.sv
// Request/exception inputs and PC/EPC/vector-table control outputs of the
// PC sequencing controller, grouped as one bundle.
interface pc_seq_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_kind;
  logic        br_taken;
  logic        exc_opc;
  logic        exc_ovf;
  logic        exc_div0;
  logic        req_ack;
  logic [2:0]  pc_mux_sel;
  logic        pc_write;
  logic        epc_write;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [1:0]  cause;
  logic        busy;
  logic        done;

  modport master (
    output req_valid, req_kind, br_taken, exc_opc, exc_ovf, exc_div0,
    input  req_ack, pc_mux_sel, pc_write, epc_write, mem_rd, mem_addr,
           cause, busy, done
  );

  modport slave (
    input  req_valid, req_kind, br_taken, exc_opc, exc_ovf, exc_div0,
    output req_ack, pc_mux_sel, pc_write, epc_write, mem_rd, mem_addr,
           cause, busy, done
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: one-cycle PC updates for normal control flow and a
// four-cycle save/vector-fetch/load sequence for exceptions.
module pc_seq_ctrl #(
  parameter logic [31:0] VEC_OPC  = 32'd253,
  parameter logic [31:0] VEC_OVF  = 32'd254,
  parameter logic [31:0] VEC_DIV0 = 32'd255
) (
  input logic           clk,
  input logic           reset,
  pc_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, UPDATE, EXC_SAVE, EXC_READ, EXC_WAIT, EXC_LOAD
  } state_t;

  localparam logic [2:0] SEL_A      = 3'b000;
  localparam logic [2:0] SEL_ULAOUT = 3'b001;
  localparam logic [2:0] SEL_SLAC   = 3'b010;
  localparam logic [2:0] SEL_EPC    = 3'b011;
  localparam logic [2:0] SEL_ULARES = 3'b101;
  localparam logic [2:0] SEL_MEM    = 3'b110;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic        pcw_q, pcw_d;
  logic        epcw_q, epcw_d;
  logic        memrd_q, memrd_d;
  logic        done_q, done_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  cause_q, cause_d;
  logic        ack;
  logic        exc_any;

  function automatic logic [2:0] update_sel(input logic [2:0] kind, input logic taken);
    logic [2:0] s;
    case (kind)
      3'd0:    s = SEL_ULARES;
      3'd1:    s = taken ? SEL_ULAOUT : SEL_ULARES;
      3'd2:    s = SEL_SLAC;
      3'd3:    s = SEL_A;
      default: s = SEL_EPC;
    endcase
    return s;
  endfunction

  assign exc_any = bus.exc_opc | bus.exc_ovf | bus.exc_div0;

  // Outputs are computed for the state being entered and registered with it.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pcw_d   = 1'b0;
    epcw_d  = 1'b0;
    memrd_d = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;
    cause_d = cause_q;
    ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (exc_any) begin
          state_d = EXC_SAVE;
          epcw_d  = 1'b1;
          if (bus.exc_opc) begin
            cause_d = 2'd1;
            addr_d  = VEC_OPC;
          end else if (bus.exc_ovf) begin
            cause_d = 2'd2;
            addr_d  = VEC_OVF;
          end else begin
            cause_d = 2'd3;
            addr_d  = VEC_DIV0;
          end
        end else if (bus.req_valid && (bus.req_kind <= 3'd4)) begin
          ack     = 1'b1;
          state_d = UPDATE;
          pcw_d   = 1'b1;
          done_d  = 1'b1;
          sel_d   = update_sel(bus.req_kind, bus.br_taken);
        end
      end
      UPDATE:   state_d = IDLE;
      EXC_SAVE: begin
        state_d = EXC_READ;
        memrd_d = 1'b1;
      end
      EXC_READ: begin
        state_d = EXC_WAIT;
        memrd_d = 1'b1;
      end
      EXC_WAIT: begin
        state_d = EXC_LOAD;
        pcw_d   = 1'b1;
        done_d  = 1'b1;
        sel_d   = SEL_MEM;
      end
      EXC_LOAD: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= SEL_A;
      pcw_q   <= 1'b0;
      epcw_q  <= 1'b0;
      memrd_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= 32'd0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pcw_q   <= pcw_d;
      epcw_q  <= epcw_d;
      memrd_q <= memrd_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      cause_q <= cause_d;
    end
  end

  assign bus.req_ack    = ack;
  assign bus.busy       = (state_q != IDLE);
  assign bus.pc_mux_sel = sel_q;
  assign bus.pc_write   = pcw_q;
  assign bus.epc_write  = epcw_q;
  assign bus.mem_rd     = memrd_q;
  assign bus.mem_addr   = addr_q;
  assign bus.cause      = cause_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed and randomized bench for pc_seq_ctrl against a transaction-level
// model that expands each request into its expected per-cycle outputs.
module tb_pc_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  pc_seq_ctrl_if bus();

  pc_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        pcw;
    logic        epcw;
    logic        memrd;
    logic        done;
    logic        busy;
    logic [2:0]  sel;
    logic [1:0]  cause;
    logic [31:0] addr;
  } exp_t;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic [2:0]  m_sel   = 3'd0;
  logic [1:0]  m_cause = 2'd0;
  logic [31:0] m_addr  = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_cycle(input string tag, input exp_t e);
    chk({tag, ".pc_write"},   32'(bus.pc_write),   32'(e.pcw));
    chk({tag, ".epc_write"},  32'(bus.epc_write),  32'(e.epcw));
    chk({tag, ".mem_rd"},     32'(bus.mem_rd),     32'(e.memrd));
    chk({tag, ".done"},       32'(bus.done),       32'(e.done));
    chk({tag, ".busy"},       32'(bus.busy),       32'(e.busy));
    chk({tag, ".pc_mux_sel"}, 32'(bus.pc_mux_sel), 32'(e.sel));
    chk({tag, ".cause"},      32'(bus.cause),      32'(e.cause));
    chk({tag, ".mem_addr"},   bus.mem_addr,        e.addr);
  endtask

  task automatic drive(input logic v, input logic [2:0] k, input logic t,
                       input logic eo, input logic ev, input logic ed);
    bus.req_valid = v;
    bus.req_kind  = k;
    bus.br_taken  = t;
    bus.exc_opc   = eo;
    bus.exc_ovf   = ev;
    bus.exc_div0  = ed;
  endtask

  // Control-flow kind to PC source, straight from the select table.
  function automatic logic [2:0] model_sel(input logic [2:0] k, input logic t);
    case (k)
      3'd0: return 3'd5;
      3'd1: return t ? 3'd1 : 3'd5;
      3'd2: return 3'd2;
      3'd3: return 3'd0;
      default: return 3'd3;
    endcase
  endfunction

  function automatic exp_t mk(input logic pcw, input logic epcw, input logic memrd,
                              input logic done, input logic busy);
    exp_t e;
    e.pcw = pcw; e.epcw = epcw; e.memrd = memrd; e.done = done; e.busy = busy;
    e.sel = m_sel; e.cause = m_cause; e.addr = m_addr;
    return e;
  endfunction

  // Called at posedge+1 of an IDLE cycle; leaves the bench at an IDLE cycle.
  task automatic run_txn(input string tag, input logic v, input logic [2:0] k,
                         input logic t, input logic eo, input logic ev, input logic ed);
    exp_t q[$];
    logic exp_ack;
    drive(v, k, t, eo, ev, ed);
    #1;
    exp_ack = !(eo || ev || ed) && v && (k <= 3'd4);
    chk({tag, ".req_ack"}, 32'(bus.req_ack), 32'(exp_ack));
    chk({tag, ".busy_at_issue"}, 32'(bus.busy), 32'd0);
    if (eo || ev || ed) begin
      m_cause = eo ? 2'd1 : (ev ? 2'd2 : 2'd3);
      m_addr  = 32'd252 + 32'(m_cause);
      q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
      q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      m_sel = 3'd6;
      q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    end else if (exp_ack) begin
      m_sel = model_sel(k, t);
      q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    end
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    foreach (q[i]) begin
      @(posedge clk);
      #1;
      chk_cycle($sformatf("%s.c%0d", tag, i), q[i]);
      if (q[i].busy) begin
        drive(1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom));
        #1;
        chk($sformatf("%s.c%0d.ack_busy", tag, i), 32'(bus.req_ack), 32'd0);
      end else begin
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    exp_t e;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cycle("reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_txn("br_taken",  1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn("br_not",    1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("jr",        1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("rte",       1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn("seq",       1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("jump",      1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("ovf_vs_req",1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    run_txn("opc_div0",  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_txn("div0",      1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_txn("reserved6", 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn("reserved7", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("idle",      1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      logic eo, ev, ed;
      eo = ($urandom_range(0, 7) == 0);
      ev = ($urandom_range(0, 7) == 0);
      ed = ($urandom_range(0, 7) == 0);
      run_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 3) != 0), 3'($urandom),
              1'($urandom), eo, ev, ed);
    end

    // Abort an exception sequence with reset while the vector read is pending.
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort.save_epc", 32'(bus.epc_write), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort.wait_memrd", 32'(bus.mem_rd), 32'd1);
    chk("abort.wait_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    m_sel = 3'd0; m_cause = 2'd0; m_addr = 32'd0;
    chk_cycle("abort.in_reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cycle($sformatf("abort.post%0d", c), e);
    end
    run_txn("recover", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 Parameters: VEC_OPC, 32'd253, vector-table byte address for invalid-opcode exception; VEC_OVF, 32'd254, for overflow; VEC_DIV0, 32'd255, for divide-by-zero.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  PC update request from main control.
REQ-005 req_kind  input  3  0=SEQ, 1=BRANCH, 2=JUMP, 3=JR, 4=RTE, 5-7 reserved.
REQ-006 br_taken  input  1  branch condition, sampled with request.
REQ-007 exc_opc, exc_ovf, exc_div0  input  1 each  exception strobes.
REQ-008 req_ack  output  1  combinational: request accepted this cycle.
REQ-009 pc_mux_sel  output  3  PC source select: 000 A, 001 ULAout, 010 SLAC, 011 EPCout, 100 MDRout, 101 ULAresult, 110 Mem.
REQ-010 pc_write  output  1  PC load enable.
REQ-011 epc_write  output  1  EPC load enable.
REQ-012 mem_rd  output  1  vector-table read strobe.
REQ-013 mem_addr  output  32  vector-table address.
REQ-014 cause  output  2  0 none, 1 opcode, 2 overflow, 3 div0; held until next exception or reset.
REQ-015 busy  output  1  high when state != IDLE.
REQ-016 done  output  1  one-cycle pulse on the cycle PC is written.

Function
REQ-017 States SHALL be IDLE, UPDATE, EXC_SAVE, EXC_READ, EXC_WAIT, EXC_LOAD; all outputs except req_ack and busy registered.
REQ-018 Requests and exceptions SHALL be sampled only in IDLE; inputs in all other states ignored, not queued.
REQ-019 In IDLE, any exception strobe high SHALL win over req_valid: next state EXC_SAVE, req_ack=0.
REQ-020 Exception priority SHALL be opcode > overflow > div0; cause and mem_addr latched from winner.
REQ-021 In IDLE with no exception, req_valid with kind 0-4 SHALL assert req_ack and go to UPDATE; reserved kinds SHALL be ignored (req_ack=0, stay IDLE).
REQ-022 UPDATE (exactly one cycle): pc_write=1, done=1, pc_mux_sel = SEQ 101; BRANCH taken 001, not taken 101; JUMP 010; JR 000; RTE 011; then IDLE.
REQ-023 EXC_SAVE: epc_write=1, pc_write=0, one cycle, then EXC_READ.
REQ-024 EXC_READ and EXC_WAIT: mem_rd=1, mem_addr=vector, one cycle each (memory read latency 1).
REQ-025 EXC_LOAD: pc_mux_sel=110, pc_write=1, done=1, mem_rd=0, then IDLE; exception sequence = 4 busy cycles.
REQ-026 pc_mux_sel SHALL hold last value when pc_write=0 and SHALL never be 111.
REQ-027 pc_write and epc_write SHALL never be high in the same cycle.
REQ-028 Back-to-back: request may be accepted in the IDLE cycle following done.

Reset
REQ-029 reset high SHALL immediately force IDLE, pc_mux_sel=000, pc_write=0, epc_write=0, mem_rd=0, mem_addr=0, cause=0, done=0, busy=0, regardless of state.
REQ-030 Reset mid-exception SHALL abort without further epc_write or pc_write; first post-reset edge in IDLE.

Verification
REQ-031 IDLE, req_valid=1, kind=1, br_taken=1 -> req_ack=1; next cycle pc_mux_sel=001, pc_write=1, done=1; then IDLE.
REQ-032 kind=1, br_taken=0 -> pc_mux_sel=101, pc_write=1; kind=3 -> 000; kind=4 -> 011.
REQ-033 exc_ovf=1 with req_valid=1 kind=2 -> req_ack=0; epc_write 1 cycle, mem_rd 2 cycles with mem_addr=254, then pc_mux_sel=110, pc_write=1, cause=2.
REQ-034 exc_opc=1 and exc_div0=1 same cycle -> cause=1, mem_addr=253; strobes pulsed during EXC_READ ignored.
REQ-035 reset asserted during EXC_WAIT -> same cycle mem_rd=0, busy=0, cause=0; no pc_write after release.
REQ-036 req_valid kind=6 -> req_ack=0, no pc_write, busy stays 0.
